// File: rtl/bit_serial_adder_if.sv
// Start/result bundle for the serial adder: the requester drives the master side,
// the adder sits on the slave side.
interface bit_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, carry
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, carry
  );
endinterface

// File: rtl/bit_serial_adder.sv
// LSB-first serial adder: one full-adder cell plus a carry flop, WIDTH edges per add.
// The result registers are separate from the partial sum so they hold between runs.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  bit_serial_adder_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] ps;
  logic [WIDTH-1:0] ps_nxt;
  logic [WIDTH-1:0] sum_q;
  logic             c;
  logic             c_nxt;
  logic             s;
  logic             carry_q;
  logic             last;
  logic [CW-1:0]    cnt;

  // Returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  // Right shift with a new MSB; written without a part-select so WIDTH == 1 works.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v, input logic msb);
    logic [WIDTH-1:0] r;
    r = v >> 1;
    r[WIDTH-1] = msb;
    return r;
  endfunction

  assign {c_nxt, s} = full_add(sa[0], sb[0], c);
  assign ps_nxt     = shift_in(ps, s);
  assign last       = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy  = (state != IDLE);
    bus.done  = (state == DONE);
    bus.sum   = sum_q;
    bus.carry = carry_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa      <= '0;
      sb      <= '0;
      c       <= 1'b0;
      cnt     <= '0;
      ps      <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sa  <= bus.a;
            sb  <= bus.b;
            c   <= bus.cin;
            cnt <= '0;
            ps  <= '0;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          c   <= c_nxt;
          ps  <= ps_nxt;
          cnt <= cnt + 1'b1;
          // Last bit: publish the result; outputs otherwise keep the previous answer.
          if (last) begin
            sum_q   <= ps_nxt;
            carry_q <= c_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Bench for bit_serial_adder at WIDTH 1, 8 and 16: transaction-level model with a
// per-cycle compare process, plus directed vectors with hand-computed results.
module tb_bit_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bit_serial_adder_if #(.WIDTH(1))  if1 ();
  bit_serial_adder_if #(.WIDTH(8))  if8 ();
  bit_serial_adder_if #(.WIDTH(16)) if16 ();

  bit_serial_adder #(.WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  bit_serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  bit_serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));

  // Index 0 -> WIDTH 1, 1 -> WIDTH 8, 2 -> WIDTH 16
  logic [15:0] a_v [3];
  logic [15:0] b_v [3];
  logic        cin_v [3];
  logic        start_v [3];
  logic [15:0] o_sum [3];
  logic        o_carry [3];
  logic        o_busy [3];
  logic        o_done [3];

  assign if1.start  = start_v[0];
  assign if1.a      = a_v[0][0:0];
  assign if1.b      = b_v[0][0:0];
  assign if1.cin    = cin_v[0];
  assign if8.start  = start_v[1];
  assign if8.a      = a_v[1][7:0];
  assign if8.b      = b_v[1][7:0];
  assign if8.cin    = cin_v[1];
  assign if16.start = start_v[2];
  assign if16.a     = a_v[2];
  assign if16.b     = b_v[2];
  assign if16.cin   = cin_v[2];

  assign o_sum[0] = {15'b0, if1.sum};
  assign o_sum[1] = {8'b0, if8.sum};
  assign o_sum[2] = if16.sum;
  assign o_carry[0] = if1.carry;
  assign o_carry[1] = if8.carry;
  assign o_carry[2] = if16.carry;
  assign o_busy[0] = if1.busy;
  assign o_busy[1] = if8.busy;
  assign o_busy[2] = if16.busy;
  assign o_done[0] = if1.done;
  assign o_done[1] = if8.done;
  assign o_done[2] = if16.done;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int wid(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 8 : 16);
  endfunction

  function automatic logic [16:0] lo_mask(input int i);
    return (17'd1 << wid(i)) - 17'd1;
  endfunction

  // Model: an accepted request yields a+b+cin exactly WIDTH edges later, done for one
  // cycle, busy until the edge after that; results hold otherwise.
  int          phase [3];
  logic [16:0] pend [3];
  logic [15:0] m_sum [3];
  logic        m_carry [3];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        phase[i]   = -1;
        pend[i]    = '0;
        m_sum[i]   = '0;
        m_carry[i] = 1'b0;
      end else if (phase[i] < 0) begin
        if (start_v[i]) begin
          pend[i]  = ({1'b0, a_v[i]} & lo_mask(i)) + ({1'b0, b_v[i]} & lo_mask(i)) + 17'(cin_v[i]);
          phase[i] = 0;
        end
      end else if (phase[i] == wid(i)) begin
        phase[i] = -1;
      end else begin
        phase[i] = phase[i] + 1;
        if (phase[i] == wid(i)) begin
          m_sum[i]   = 16'(pend[i] & lo_mask(i));
          m_carry[i] = pend[i][wid(i)];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("busy_w%0d", wid(i)), 32'(o_busy[i]), 32'(phase[i] >= 0));
        check($sformatf("done_w%0d", wid(i)), 32'(o_done[i]), 32'(phase[i] == wid(i)));
        check($sformatf("sum_w%0d", wid(i)), 32'(o_sum[i]), 32'(m_sum[i]));
        check($sformatf("carry_w%0d", wid(i)), 32'(o_carry[i]), 32'(m_carry[i]));
      end
    end
  end

  task automatic wait_done8(output int k);
    k = 0;
    while (k < 30 && !o_done[1]) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input logic [7:0] es, input logic ec, input string nm);
    int k;
    @(negedge clk);
    a_v[1] = 16'(a); b_v[1] = 16'(b); cin_v[1] = ci; start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    check({nm, " busy_e0"}, 32'(o_busy[1]), 32'd1);
    wait_done8(k);
    check({nm, " latency"}, 32'(k), 32'd8);
    check({nm, " sum"}, 32'(o_sum[1]), 32'(es));
    check({nm, " carry"}, 32'(o_carry[1]), 32'(ec));
    check({nm, " model_sum"}, 32'({m_carry[1], m_sum[1]}), 32'({ec, 8'b0, es}));
    @(negedge clk);
    check({nm, " done_fall"}, 32'({o_busy[1], o_done[1]}), 32'd0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 3; i++) begin
      a_v[i] = '0; b_v[i] = '0; cin_v[i] = 1'b0; start_v[i] = 1'b0; phase[i] = -1;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_w%0d", wid(i)),
            32'({o_busy[i], o_done[i], o_carry[i], o_sum[i]}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    add8(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, "basic");

    // Result of the previous add must persist through the whole next run
    @(negedge clk);
    a_v[1] = 16'h80; b_v[1] = 16'h80; cin_v[1] = 1'b0; start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    k = 0;
    while (k < 30 && !o_done[1]) begin
      check("hold sum", 32'(o_sum[1]), 32'h4B);
      @(negedge clk);
      k++;
    end
    check("hold latency", 32'(k), 32'd8);
    check("hold result", 32'({o_carry[1], o_sum[1]}), 32'h1_0000);
    @(negedge clk);

    add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff+01");
    add8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ff+ff+1");
    add8(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "0+0+1");

    // start held through RUN with new operands: ignored until after DONE
    @(negedge clk);
    a_v[1] = 16'h10; b_v[1] = 16'h20; cin_v[1] = 1'b0; start_v[1] = 1'b1;
    @(negedge clk);
    a_v[1] = 16'hAA; b_v[1] = 16'h55;
    wait_done8(k);
    check("ign latency", 32'(k), 32'd8);
    check("ign first", 32'({o_carry[1], o_sum[1]}), 32'h30);
    @(negedge clk);
    check("ign idle gap", 32'(o_busy[1]), 32'd0);
    @(negedge clk);
    start_v[1] = 1'b0;
    check("ign reaccept", 32'(o_busy[1]), 32'd1);
    wait_done8(k);
    check("ign2 latency", 32'(k), 32'd8);
    check("ign second", 32'({o_carry[1], o_sum[1]}), 32'hFF);
    @(negedge clk);

    // Asynchronous reset in the middle of a run
    @(negedge clk);
    a_v[1] = 16'h33; b_v[1] = 16'h44; cin_v[1] = 1'b0; start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst busy", 32'(o_busy[1]), 32'd0);
    check("rst sum", 32'(o_sum[1]), 32'd0);
    check("rst carry", 32'(o_carry[1]), 32'd0);
    repeat (6) begin
      @(negedge clk);
      check("rst no done", 32'(o_done[1]), 32'd0);
    end
    rst_n = 1'b1;
    add8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "post reset");

    // Random sweep: all 1000 at WIDTH 8, the first 100 also at WIDTH 1 and 16
    for (int it = 0; it < 1000; it++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        a_v[i] = 16'($urandom);
        b_v[i] = 16'($urandom);
        cin_v[i] = 1'($urandom_range(0, 1));
      end
      start_v[1] = 1'b1;
      start_v[0] = (it < 100);
      start_v[2] = (it < 100);
      @(negedge clk);
      for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
      k = 0;
      while (k < 40 && (o_busy[0] || o_busy[1] || o_busy[2])) begin
        @(negedge clk);
        k++;
      end
      check("rand idle timeout", 32'(k < 40), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_serial_adder.md
# bit_serial_adder

Sequential LSB-first serial adder that computes `a + b + cin` over `WIDTH` clock cycles using a single full-adder bit cell and a carry flip-flop. It sits in front of the combinational full-adder path in the arithmetic datapath. It accepts one operand pair per start request and feeds back one carry per cycle. It reports the registered `WIDTH`-bit sum and carry-out with a one-cycle `done` pulse.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range is `WIDTH >= 1`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: request to begin an addition; sampled only in IDLE.
- `a`, input, `WIDTH`: operand A; captured on the accepting edge.
- `b`, input, `WIDTH`: operand B; captured on the accepting edge.
- `cin`, input, 1: carry-in; captured on the accepting edge.
- `busy`, output, 1: high whenever the state is not IDLE.
- `done`, output, 1: one-cycle pulse; `sum` and `carry` are valid from this cycle on.
- `sum`, output, `WIDTH`: registered result, `(a + b + cin) mod 2^WIDTH`.
- `carry`, output, 1: registered carry-out, bit `WIDTH` of `a + b + cin`.

## Operation
- **States:** IDLE, RUN, DONE.
- **Internal registers:**
  - operand shift registers `sa` and `sb`, each `WIDTH` bits;
  - carry flop `c`;
  - bit counter `cnt`, `$clog2(WIDTH+1)` bits;
  - partial-sum shift register `ps`, `WIDTH` bits;
  - output registers `sum` and `carry`, kept separate from `ps`.
- **IDLE:**
  - If `start` is 1: load `sa <= a`, `sb <= b`, `c <= cin`, `cnt <= 0`, `ps <= 0`, then go to RUN.
  - If `start` is 0: hold all registers.
- **RUN, each edge:**
  - Compute bit `s = sa[0] ^ sb[0] ^ c`.
  - Update `c <= (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0]))`.
  - Shift `ps <= {s, ps[WIDTH-1:1]}`, and shift `sa` and `sb` right by one.
  - Increment `cnt`.
  - On the edge where `cnt == WIDTH-1`, the last bit is processed. On that edge: `sum <= {s, ps[WIDTH-1:1]}`, `carry <=` the new carry, `done <= 1`, and go to DONE.
- **DONE:**
  - Lasts exactly one cycle; `done` is high only in this cycle.
  - Next edge: `done <= 0`, go to IDLE.
  - `start` is ignored in DONE.
- **Start handling:** `start` is ignored in RUN and DONE. No queuing, and captured operands are not disturbed.
- **Output hold:** `sum` and `carry` change only on entry to DONE and on reset. Between runs, and throughout a new run, they hold the previous result.
- **`WIDTH == 1`:** RUN lasts one edge; the result is a plain full-adder evaluation.

## Timing
- **Reset values:**
  - state IDLE;
  - `busy` = 0, `done` = 0, `sum` = 0, `carry` = 0;
  - all internal registers 0.
- **Reset at any time, including mid-RUN:**
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - The in-flight operation is discarded and no `done` is produced.
  - The first accepted `start` after `rst_n` rises behaves as from power-up.
- **Latency:**
  - Call the edge that samples `start` in IDLE E0.
  - `busy` rises after E0.
  - `done`, `sum` and `carry` update on edge E`WIDTH`.
  - DONE → IDLE on edge E(`WIDTH`+1); `busy` and `done` fall there.
- **Throughput:** one addition per `WIDTH`+2 cycles. `start` held continuously high is accepted on the first IDLE edge after each DONE.
- **Input timing:** `a`, `b` and `cin` need only be stable at the accepting edge.

## Test plan
- **Basic add:** `WIDTH`=8, `a`=8'h3C, `b`=8'h0F, `cin`=0, `start` pulsed 1 cycle → `sum`=8'h4B, `carry`=0. `done` is high for exactly one cycle, updated on edge E8; `busy` high from E0 to E9.
- **Carry extremes:**
  - `a`=8'hFF, `b`=8'h01, `cin`=0 → `sum`=8'h00, `carry`=1.
  - `a`=8'hFF, `b`=8'hFF, `cin`=1 → `sum`=8'hFF, `carry`=1.
  - `a`=0, `b`=0, `cin`=1 → `sum`=8'h01, `carry`=0.
- **Ignored start:**
  - Start with 8'h10 + 8'h20, then hold `start`=1 with `a`=8'hAA, `b`=8'h55 during RUN → first result 8'h30.
  - The next run starts only after DONE and produces 8'hFF, `carry`=0.
- **Reset mid-run:** pull `rst_n` low at cycle 4 of RUN, between clock edges → `busy`, `sum`, `carry` are 0 immediately, with no `done`. After release, 8'h01+8'h01 → `sum`=8'h02.
- **Output hold:** after the result 8'h4B, start 8'h80+8'h80 → `sum` reads 8'h4B through the whole RUN, then 8'h00 with `carry`=1 at `done`.
- **Random and width sweep:** 1000 random `a`/`b`/`cin` at `WIDTH`=8, plus 100 at `WIDTH`=1 and 100 at `WIDTH`=16 → `{carry, sum}` equals `a+b+cin` every time, with `done` latency fixed at `WIDTH`.
